mac_operand_queue: RTL

Controller and storage for the MAC unit's 4-entry circular operand buffer. It maintains the head pointer, tail pointer and round (wrap) bit, and accepts operands from the producer with a valid/ready handshake. It issues operands to the MAC datapath in FIFO order with a valid/ready handshake. It publishes occupancy status (count, full, empty, per-entry ready mask) and sequences a drain-on-flush operation.

---
 rtl/mac_operand_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mac_operand_queue.sv
// 4-entry circular operand buffer feeding the MAC datapath, with occupancy status and drain-on-flush.
// Optional high-water-mark register enabled by defining MAC_OPERAND_QUEUE_HWM_EN.
//
// state | meaning
// RUN   | normal operation, producer may push
// DRAIN | producer blocked, pops continue until empty

module mac_operand_queue #(
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4,
    parameter int DataWidth   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DataWidth-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DataWidth-1:0]   out_data,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [BufferWidth-1:0] HP,
    output logic [BufferWidth-1:0] TP,
    output logic                   Round,
    output logic [BufferWidth:0]   Count,
    output logic                   Full,
    output logic                   Empty,
    output logic [BufferSize-1:0]  Ready,
    output logic [BufferWidth:0]   HWM
);

    localparam logic [BufferWidth:0]   SIZE_EXT = (BufferWidth+1)'(BufferSize);
    localparam logic [BufferWidth-1:0] LAST     = BufferWidth'(BufferSize-1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                 state, state_next;
    logic [DataWidth-1:0]   mem [BufferSize];
    logic [BufferWidth-1:0] hp, tp;
    logic                   round;
    logic                   push, pop, ptr_eq;
    logic [BufferWidth:0]   count;
    logic [BufferSize-1:0]  ready_base;
    logic [2*BufferSize-1:0] ready_dbl;

    assign ptr_eq    = (hp == tp);
    assign Empty     = !round && ptr_eq;
    assign Full      = round && ptr_eq;
    assign count     = round ? ({1'b0, tp} + SIZE_EXT - {1'b0, hp}) : ({1'b0, tp} - {1'b0, hp});
    assign Count     = count;
    assign HP        = hp;
    assign TP        = tp;
    assign Round     = round;

    assign in_ready  = !Full && (state == RUN);
    assign out_valid = !Empty;
    assign out_data  = mem[hp];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy mask starts at the head and wraps around, so rotate rather than shift.
    always_comb begin
        ready_base = '0;
        for (int i = 0; i < BufferSize; i++) begin
            if ((BufferWidth+1)'(i) < count) ready_base[i] = 1'b1;
        end
    end
    assign ready_dbl = {ready_base, ready_base} << hp;
    assign Ready     = ready_dbl[2*BufferSize-1:BufferSize];

    always_comb begin
        state_next = state;
        flush_done = 1'b0;
        case (state)
            RUN:   if (flush) state_next = DRAIN;
            DRAIN: if (Empty) begin
                flush_done = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hp    <= '0;
            tp    <= '0;
            round <= 1'b0;
            state <= RUN;
        end else begin
            state <= state_next;
            if (push) tp <= tp + 1'b1;
            if (pop)  hp <= hp + 1'b1;
            // Both pointers wrapping in one cycle cancels out.
            round <= round ^ (push && (tp == LAST)) ^ (pop && (hp == LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tp] <= in_data;
    end

`ifdef MAC_OPERAND_QUEUE_HWM_EN
    logic [BufferWidth:0] count_next, hwm;

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                    hwm <= '0;
        else if (count_next > hwm)  hwm <= count_next;
    end

    assign HWM = hwm;
`else
    assign HWM = '0;
`endif

endmodule
